lift_platform: RTL and testbench

- Downstream consumer of the pressure-plate detector's level output `is_button_push`.
- Drives the vertical position of one moving lift platform in the level.
- Motion is paced by the per-frame vsync strobe.
- Outputs feed the platform sprite renderer and the character collision logic.

---
 rtl/lift_platform.sv | 136 +++++++++++++
 tb/tb_lift_platform.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lift_platform.sv
// Frame-paced lift platform: lowers while the pressure plate is held, dwells at the bottom,
// and returns to rest only when built with LIFT_AUTO_RETURN_EN (otherwise it is one-shot).
module lift_platform #(
    parameter logic [9:0] TOP_Y       = 10'd300,
    parameter logic [9:0] BOTTOM_Y    = 10'd360,
    parameter logic [3:0] STEP        = 4'd2,
    parameter logic [7:0] HOLD_FRAMES = 8'd60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       button_active,
    input  logic       blocked,
    output logic [9:0] plat_y,
    output logic       moving,
    output logic       at_bottom
);

    typedef enum logic [2:0] {
        S_TOP    = 3'd0,
        S_LOWER  = 3'd1,
        S_BOTTOM = 3'd2,
        S_DWELL  = 3'd3,
        S_RAISE  = 3'd4
    } state_t;

    // A zero hold time behaves like a single-frame dwell.
    localparam logic [7:0] HOLD_LAST = (HOLD_FRAMES == 8'd0) ? 8'd0 : HOLD_FRAMES - 8'd1;

    state_t     state_q, state_d;
    logic [9:0] plat_y_q, plat_y_d;
    logic [7:0] dwell_q, dwell_d;
    logic       frame_clk_q;
    logic       moving_q, moving_d;
    logic       at_bottom_q, at_bottom_d;
    logic       tick;

    function automatic logic [9:0] step_down(input logic [9:0] y);
        logic [10:0] sum;
        sum = {1'b0, y} + {7'b0, STEP};
        return (sum > {1'b0, BOTTOM_Y}) ? BOTTOM_Y : sum[9:0];
    endfunction

    function automatic logic [9:0] step_up(input logic [9:0] y);
        logic [10:0] floor_plus_step;
        floor_plus_step = {1'b0, TOP_Y} + {7'b0, STEP};
        return ({1'b0, y} >= floor_plus_step) ? (y - {6'b0, STEP}) : TOP_Y;
    endfunction

    assign tick = frame_clk & ~frame_clk_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_TOP;
            plat_y_q    <= TOP_Y;
            dwell_q     <= 8'd0;
            frame_clk_q <= 1'b0;
            moving_q    <= 1'b0;
            at_bottom_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            plat_y_q    <= plat_y_d;
            dwell_q     <= dwell_d;
            frame_clk_q <= frame_clk;
            moving_q    <= moving_d;
            at_bottom_q <= at_bottom_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        plat_y_d = plat_y_q;
        dwell_d  = dwell_q;
        case (state_q)
            S_TOP: begin
                plat_y_d = TOP_Y;
                if (tick && button_active) state_d = S_LOWER;
            end
            S_LOWER: begin
                if (tick) begin
`ifdef LIFT_AUTO_RETURN_EN
                    // Releasing the plate reverses immediately, even while blocked.
                    if (!button_active) begin
                        plat_y_d = step_up(plat_y_q);
                        state_d  = (step_up(plat_y_q) == TOP_Y) ? S_TOP : S_RAISE;
                    end else
`endif
                    if (!blocked) begin
                        plat_y_d = step_down(plat_y_q);
                        if (step_down(plat_y_q) == BOTTOM_Y) state_d = S_BOTTOM;
                    end
                end
            end
            S_BOTTOM: begin
                if (tick) begin
                    state_d = S_DWELL;
                    dwell_d = 8'd0;
                end
            end
            S_DWELL: begin
                if (tick) begin
                    if (dwell_q >= HOLD_LAST) begin
                        dwell_d = HOLD_LAST;
`ifdef LIFT_AUTO_RETURN_EN
                        if (!button_active) state_d = S_RAISE;
`endif
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
            end
            S_RAISE: begin
                if (tick) begin
                    plat_y_d = step_up(plat_y_q);
                    if (step_up(plat_y_q) == TOP_Y) state_d = S_TOP;
                end
            end
            default: begin
                state_d  = S_TOP;
                plat_y_d = TOP_Y;
                dwell_d  = 8'd0;
            end
        endcase
    end

    // Status flags follow the next state so they switch on the same edge as the state.
    always_comb begin
        moving_d    = (state_d == S_LOWER) || (state_d == S_RAISE);
        at_bottom_d = (state_d == S_BOTTOM) || (state_d == S_DWELL);
    end

    assign plat_y    = plat_y_q;
    assign moving    = moving_q;
    assign at_bottom = at_bottom_q;

endmodule

// File: tb/tb_lift_platform.sv
// Bench for lift_platform: fixed vector table, hand-written corner sequences,
// and randomized frames checked against a frame-level reference model.
module tb_lift_platform;

    localparam int TOP_Y    = 300;
    localparam int BOTTOM_Y = 360;
    localparam int STEP     = 2;
    localparam int HOLD     = 60;

    localparam int P_TOP = 0, P_LOWER = 1, P_BOTTOM = 2, P_DWELL = 3, P_RAISE = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       button_active = 1'b0;
    logic       blocked = 1'b0;
    logic [9:0] plat_y;
    logic       moving;
    logic       at_bottom;

    int checks = 0;
    int errors = 0;

    int m_phase;
    int m_y;
    int m_dwell_ticks;
    bit auto_return;

    typedef struct {
        int reps;
        int width;
        bit btn;
        bit blk;
        int exp_y;
        bit exp_mov;
        bit exp_atb;
    } vec_t;

    vec_t vecs[10];

    lift_platform dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .button_active(button_active),
        .blocked      (blocked),
        .plat_y       (plat_y),
        .moving       (moving),
        .at_bottom    (at_bottom)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input int y, input int mov, input int atb);
        check({name, ".plat_y"}, int'(plat_y), y);
        check({name, ".moving"}, int'(moving), mov);
        check({name, ".at_bottom"}, int'(at_bottom), atb);
    endtask

    // Frame-level reference: one call per frame_clk rising edge.
    task automatic model_frame(input bit btn, input bit blk);
        int hold_eff;
        hold_eff = (HOLD < 1) ? 1 : HOLD;
        case (m_phase)
            P_TOP: if (btn) m_phase = P_LOWER;
            P_LOWER: begin
                if (auto_return && !btn) begin
                    m_y = (m_y - STEP < TOP_Y) ? TOP_Y : m_y - STEP;
                    m_phase = (m_y == TOP_Y) ? P_TOP : P_RAISE;
                end else if (!blk) begin
                    m_y = (m_y + STEP > BOTTOM_Y) ? BOTTOM_Y : m_y + STEP;
                    if (m_y == BOTTOM_Y) m_phase = P_BOTTOM;
                end
            end
            P_BOTTOM: begin
                m_phase = P_DWELL;
                m_dwell_ticks = 0;
            end
            P_DWELL: begin
                m_dwell_ticks++;
                if (m_dwell_ticks >= hold_eff && auto_return && !btn) m_phase = P_RAISE;
            end
            default: begin
                m_y = (m_y - STEP < TOP_Y) ? TOP_Y : m_y - STEP;
                if (m_y == TOP_Y) m_phase = P_TOP;
            end
        endcase
    endtask

    task automatic model_reset();
        m_phase = P_TOP;
        m_y = TOP_Y;
        m_dwell_ticks = 0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        frame_clk = 1'b0;
        button_active = 1'b0;
        blocked = 1'b0;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        model_reset();
    endtask

    // One frame strobe held high for 'width' clocks, then a low clock.
    task automatic frame(input int width, input bit btn, input bit blk);
        @(negedge Clk);
        button_active = btn;
        blocked = blk;
        frame_clk = 1'b1;
        repeat (width) @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        model_frame(btn, blk);
    endtask

    initial begin
`ifdef LIFT_AUTO_RETURN_EN
        auto_return = 1'b1;
`else
        auto_return = 1'b0;
`endif
        vecs[0] = '{5,  1, 1'b0, 1'b0, 300, 1'b0, 1'b0};
        vecs[1] = '{1,  1, 1'b1, 1'b0, 300, 1'b1, 1'b0};
        vecs[2] = '{15, 1, 1'b1, 1'b0, 330, 1'b1, 1'b0};
        vecs[3] = '{10, 3, 1'b1, 1'b1, 330, 1'b1, 1'b0};
        vecs[4] = '{1,  1, 1'b1, 1'b0, 332, 1'b1, 1'b0};
        vecs[5] = '{2,  8, 1'b1, 1'b0, 336, 1'b1, 1'b0};
        vecs[6] = '{12, 1, 1'b1, 1'b0, 360, 1'b0, 1'b1};
        vecs[7] = '{1,  1, 1'b1, 1'b0, 360, 1'b0, 1'b1};
        vecs[8] = '{60, 2, 1'b1, 1'b0, 360, 1'b0, 1'b1};
        vecs[9] = '{5,  1, 1'b1, 1'b1, 360, 1'b0, 1'b1};

        do_reset();
        check_all("reset", 300, 0, 0);

        for (int i = 0; i < 10; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) frame(vecs[i].width, vecs[i].btn, vecs[i].blk);
            check_all($sformatf("vec%0d", i), vecs[i].exp_y, int'(vecs[i].exp_mov), int'(vecs[i].exp_atb));
        end

        // Asynchronous reset mid-descent, no clock edge needed.
        do_reset();
        frame(1, 1'b1, 1'b0);
        repeat (25) frame(1, 1'b1, 1'b0);
        check_all("pre_async", 350, 1, 0);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1 check_all("async_reset", 300, 0, 0);
        @(negedge Clk);
        Reset = 1'b0;
        frame(1, 1'b1, 1'b0);
        check_all("after_async", 300, 1, 0);

        // Button release at 340 during descent, then dwell expiry.
        do_reset();
        frame(1, 1'b1, 1'b0);
        repeat (20) frame(1, 1'b1, 1'b0);
        check_all("at340", 340, 1, 0);
`ifdef LIFT_AUTO_RETURN_EN
        frame(1, 1'b0, 1'b1);
        check_all("reverse", 338, 1, 0);
        repeat (19) frame(1, 1'b0, 1'b0);
        check_all("back_top", 300, 0, 0);
        frame(1, 1'b1, 1'b0);
        repeat (30) frame(1, 1'b1, 1'b0);
        check_all("bottom2", 360, 0, 1);
        frame(1, 1'b0, 1'b0);
        repeat (59) frame(1, 1'b0, 1'b0);
        check_all("dwell59", 360, 0, 1);
        frame(1, 1'b0, 1'b0);
        check_all("dwell_exit", 360, 1, 0);
        frame(1, 1'b0, 1'b1);
        check_all("raise_step", 358, 1, 0);
`else
        frame(1, 1'b0, 1'b0);
        check_all("no_reverse", 342, 1, 0);
        repeat (9) frame(1, 1'b0, 1'b0);
        check_all("bottom2", 360, 0, 1);
        frame(1, 1'b0, 1'b0);
        repeat (60) frame(1, 1'b0, 1'b0);
        check_all("dwell60", 360, 0, 1);
        repeat (10) frame(1, 1'b0, 1'b0);
        check_all("dwell_stuck", 360, 0, 1);
`endif

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int n = 0; n < 150; n++) begin
                bit rb, rk;
                int rw;
                rb = ($urandom_range(0, 3) != 0);
                rk = ($urandom_range(0, 4) == 0);
                rw = $urandom_range(1, 4);
                frame(rw, rb, rk);
                check_all($sformatf("rnd%0d_%0d", ep, n), m_y,
                          int'(m_phase == P_LOWER || m_phase == P_RAISE),
                          int'(m_phase == P_BOTTOM || m_phase == P_DWELL));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
